// File: rtl/riscv_pkg.sv
// Shared types for the RV32I core: branch funct3 codes and pipeline control bundles.
package riscv_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Controls carried into Execute (destination register kept beside it, width is a parameter).
    typedef struct packed {
        logic       valid;
        logic       reg_write;
        logic       mem_write;
        logic       jump;
        logic       branch;
        logic       alu_src;
        logic [1:0] result_src;
        logic [2:0] alu_control;
        logic [2:0] funct3;
    } ctrl_e_t;

    // Controls still needed in Memory.
    typedef struct packed {
        logic       valid;
        logic       reg_write;
        logic       mem_write;
        logic [1:0] result_src;
        logic [2:0] funct3;
    } ctrl_m_t;

    // Controls still needed in Writeback.
    typedef struct packed {
        logic       valid;
        logic       reg_write;
        logic [1:0] result_src;
    } ctrl_w_t;

    // All-zero bundle: no register write, no memory write, no branch or jump.
    localparam ctrl_e_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/branch_cond.sv
// Branch condition decode from funct3 and the ALU subtraction flags.
module branch_cond
    import riscv_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       ZeroE,
    input  logic       LtE,
    input  logic       LtuE,
    output logic       taken
);

    // Select the flag (or its inverse) that the branch type tests; unused codes never take.
    always_comb begin
        taken = 1'b0;
        case (funct3)
            F3_BEQ:  taken = ZeroE;
            F3_BNE:  taken = ~ZeroE;
            F3_BLT:  taken = LtE;
            F3_BGE:  taken = ~LtE;
            F3_BLTU: taken = LtuE;
            F3_BGEU: taken = ~LtuE;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/ctrl_pipe.sv
// Control pipeline D -> E -> M -> W with Execute-stage branch resolution.
module ctrl_pipe
    import riscv_pkg::*;
#(
    parameter int unsigned REG_AW = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ValidD,
    input  logic              RegWriteD,
    input  logic              MemWriteD,
    input  logic              JumpD,
    input  logic              BranchD,
    input  logic              ALUSrcD,
    input  logic [1:0]        ResultSrcD,
    input  logic [2:0]        ALUControlD,
    input  logic [2:0]        funct3D,
    input  logic [REG_AW-1:0] RdD,
    input  logic              FlushE,
    input  logic              ZeroE,
    input  logic              LtE,
    input  logic              LtuE,
    output logic              ValidE,
    output logic              ALUSrcE,
    output logic [2:0]        ALUControlE,
    output logic [1:0]        ResultSrcE,
    output logic              RegWriteE,
    output logic [REG_AW-1:0] RdE,
    output logic              PCSrcE,
    output logic              ValidM,
    output logic              RegWriteM,
    output logic              MemWriteM,
    output logic [1:0]        ResultSrcM,
    output logic [2:0]        funct3M,
    output logic [REG_AW-1:0] RdM,
    output logic              ValidW,
    output logic              RegWriteW,
    output logic [1:0]        ResultSrcW,
    output logic [REG_AW-1:0] RdW
);

    ctrl_e_t           ctrl_e_d, ctrl_e_q;
    ctrl_m_t           ctrl_m_d, ctrl_m_q;
    ctrl_w_t           ctrl_w_d, ctrl_w_q;
    logic [REG_AW-1:0] rd_e_d, rd_e_q;
    logic [REG_AW-1:0] rd_m_q;
    logic [REG_AW-1:0] rd_w_q;
    logic              cond_taken;

    // E next state: bubble on flush or invalid D, flush taking priority.
    always_comb begin
        ctrl_e_d = CTRL_BUBBLE;
        rd_e_d   = '0;
        if (!FlushE && ValidD) begin
            ctrl_e_d.valid       = 1'b1;
            ctrl_e_d.reg_write   = RegWriteD;
            ctrl_e_d.mem_write   = MemWriteD;
            ctrl_e_d.jump        = JumpD;
            ctrl_e_d.branch      = BranchD;
            ctrl_e_d.alu_src     = ALUSrcD;
            ctrl_e_d.result_src  = ResultSrcD;
            ctrl_e_d.alu_control = ALUControlD;
            ctrl_e_d.funct3      = funct3D;
            rd_e_d               = RdD;
        end
    end

    // M and W next state: plain copies of the stage before, bubbles included.
    always_comb begin
        ctrl_m_d.valid      = ctrl_e_q.valid;
        ctrl_m_d.reg_write  = ctrl_e_q.reg_write;
        ctrl_m_d.mem_write  = ctrl_e_q.mem_write;
        ctrl_m_d.result_src = ctrl_e_q.result_src;
        ctrl_m_d.funct3     = ctrl_e_q.funct3;
        ctrl_w_d.valid      = ctrl_m_q.valid;
        ctrl_w_d.reg_write  = ctrl_m_q.reg_write;
        ctrl_w_d.result_src = ctrl_m_q.result_src;
    end

    // Stage registers; reset drops every stage to a bubble immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_e_q <= CTRL_BUBBLE;
            ctrl_m_q <= '0;
            ctrl_w_q <= '0;
            rd_e_q   <= '0;
            rd_m_q   <= '0;
            rd_w_q   <= '0;
        end else begin
            ctrl_e_q <= ctrl_e_d;
            ctrl_m_q <= ctrl_m_d;
            ctrl_w_q <= ctrl_w_d;
            rd_e_q   <= rd_e_d;
            rd_m_q   <= rd_e_q;
            rd_w_q   <= rd_m_q;
        end
    end

    branch_cond u_branch_cond (
        .funct3 (ctrl_e_q.funct3),
        .ZeroE  (ZeroE),
        .LtE    (LtE),
        .LtuE   (LtuE),
        .taken  (cond_taken)
    );

    // Branch/jump redirect, gated by the E valid bit so bubbles never redirect.
    always_comb begin
        PCSrcE = ctrl_e_q.valid & ((ctrl_e_q.branch & cond_taken) | ctrl_e_q.jump);
    end

    assign ValidE      = ctrl_e_q.valid;
    assign ALUSrcE     = ctrl_e_q.alu_src;
    assign ALUControlE = ctrl_e_q.alu_control;
    assign ResultSrcE  = ctrl_e_q.result_src;
    assign RegWriteE   = ctrl_e_q.reg_write;
    assign RdE         = rd_e_q;

    assign ValidM      = ctrl_m_q.valid;
    assign RegWriteM   = ctrl_m_q.reg_write;
    assign MemWriteM   = ctrl_m_q.mem_write;
    assign ResultSrcM  = ctrl_m_q.result_src;
    assign funct3M     = ctrl_m_q.funct3;
    assign RdM         = rd_m_q;

    assign ValidW      = ctrl_w_q.valid;
    assign RegWriteW   = ctrl_w_q.reg_write;
    assign ResultSrcW  = ctrl_w_q.result_src;
    assign RdW         = rd_w_q;

endmodule
